fifo_credit_arbiter: RTL and testbench

//  Round-robin arbiter sharing one credit FIFO write port among NUM_REQ packet sources.

---
 rtl/fifo_credit_arb_pkg.sv | 17 +
 rtl/fifo_credit_arbiter_rr_picker.sv | 30 +++
 rtl/fifo_credit_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_credit_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_credit_arb_pkg.sv
// Shared types and width helpers for the credit FIFO round-robin arbiter.
package fifo_credit_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned credit_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/fifo_credit_arbiter_rr_picker.sv
// Rotating-priority search: first set bit of i_req starting at i_ptr, wrapping at N.
module rr_picker
  import fifo_credit_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = req_idx_w(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_winner,
  output logic             o_found
);

  logic [IDX_W-1:0] w_idx;

  // Walk from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      w_idx = IDX_W'((int'(i_ptr) + i) % int'(N));
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_credit_arbiter.sv
// Round-robin packet arbiter feeding one credit FIFO write port.
// Optional per-requester packet counters on pkt_cnt when FIFO_CREDIT_ARB_STATS_EN is defined.
module fifo_credit_arbiter
  import fifo_credit_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 8,
  parameter  int unsigned MAX_BURST  = 16,
  localparam int unsigned IDX_W      = req_idx_w(NUM_REQ),
  localparam int unsigned CRED_W     = credit_w(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic [CRED_W-1:0]             credit_count,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          burst_err
`ifdef FIFO_CREDIT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         pkt_cnt
`endif
);

  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IDX_W-1:0]    r_grant_id;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [BCNT_W-1:0]   r_beat_cnt;
  logic                r_burst_err;
  logic [IDX_W-1:0]    w_pick_id;
  logic                w_pick_found;
  logic                w_credit_ok;
  logic                w_accept;
  logic                w_last;
  logic [IDX_W-1:0]    w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_req_data[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_pick_id),
    .o_found  (w_pick_found)
  );

  assign w_credit_ok = (credit_count != '0);
  assign w_accept    = out_valid && out_ready;
  assign w_last      = req_last[r_grant_id];
  assign w_ptr_nxt   = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);
  assign grant_valid = (r_state == LOCKED);
  assign grant_id    = r_grant_id;
  assign burst_err   = r_burst_err;
  assign out_data    = w_req_data[r_grant_id];

  // Next state and beat handshake; out_valid never depends on out_ready.
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (w_pick_found && w_credit_ok) w_state_nxt = LOCKED;
      end
      LOCKED: begin
        out_valid             = req_valid[r_grant_id] && w_credit_ok;
        req_ready[r_grant_id] = out_ready && w_credit_ok;
        if (w_accept && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_grant_id  <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_burst_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_pick_found && w_credit_ok) r_grant_id <= w_pick_id;
      if (r_state == LOCKED && w_accept) begin
        if (w_last) begin
          r_rr_ptr   <= w_ptr_nxt;
          r_beat_cnt <= '0;
        end else begin
          if (r_beat_cnt == BCNT_W'(MAX_BURST - 1)) r_burst_err <= 1'b1;
          if (r_beat_cnt != BCNT_W'(MAX_BURST)) r_beat_cnt <= r_beat_cnt + BCNT_W'(1);
        end
      end
    end
  end

`ifdef FIFO_CREDIT_ARB_STATS_EN
  logic [15:0] r_pkt_cnt [NUM_REQ];

  // Completed-packet counters, wrapping at 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) r_pkt_cnt[i] <= '0;
    end else if (r_state == LOCKED && w_accept && w_last) begin
      r_pkt_cnt[r_grant_id] <= r_pkt_cnt[r_grant_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pkt
    assign pkt_cnt[g*16 +: 16] = r_pkt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_fifo_credit_arbiter.sv
// Directed bench for fifo_credit_arbiter: vector table for round-robin, hand sequences for corner cases.
module tb_fifo_credit_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MB = 4;
  localparam int unsigned CW = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     credit_count;
  logic              grant_valid;
  logic [1:0]        grant_id;
  logic              burst_err;
`ifdef FIFO_CREDIT_ARB_STATS_EN
  logic [NR*16-1:0]  pkt_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  fifo_credit_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_last     (req_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .credit_count (credit_count),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .burst_err    (burst_err)
`ifdef FIFO_CREDIT_ARB_STATS_EN
    ,
    .pkt_cnt      (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] l;
    logic          rdy;
    logic [CW-1:0] cred;
    logic          e_ov;
    logic [NR-1:0] e_rr;
    logic          e_gv;
    logic [1:0]    e_gid;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] l,
                       input logic rdy, input logic [CW-1:0] cred);
    req_valid    = v;
    req_last     = l;
    out_ready    = rdy;
    credit_count = cred;
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] d);
    req_data[idx*DW +: DW] = d;
  endtask

  function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR-1:0] l, input logic rdy,
                              input logic [CW-1:0] cred, input logic e_ov, input logic [NR-1:0] e_rr,
                              input logic e_gv, input logic [1:0] e_gid, input logic [DW-1:0] e_data);
    vec_t t;
    t.v = v; t.l = l; t.rdy = rdy; t.cred = cred; t.e_ov = e_ov;
    t.e_rr = e_rr; t.e_gv = e_gv; t.e_gid = e_gid; t.e_data = e_data;
    return t;
  endfunction

  initial begin
    // Round-robin over four 1-beat sources: idle/locked alternation, grant order 0,1,2,3,0.
    tbl[0] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0);
    tbl[1] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA000_0000);
    tbl[2] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0);
    tbl[3] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA000_0001);
    tbl[4] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b0, 4'b0000, 1'b0, 2'd1, 32'h0);
    tbl[5] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA000_0002);
    tbl[6] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b0, 4'b0000, 1'b0, 2'd2, 32'h0);
    tbl[7] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA000_0003);
    tbl[8] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b0, 4'b0000, 1'b0, 2'd3, 32'h0);
    tbl[9] = mk(4'hF, 4'hF, 1'b1, 4'd8, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA000_0000);

    rst = 1'b1;
    drive(4'h0, 4'h0, 1'b1, 4'd8);
    for (int i = 0; i < int'(NR); i++) set_data(i, 32'hA000_0000 + DW'(i));
    tick();
    tick();
    rst = 1'b0;
    #2;
    chk("reset_grant_valid", 32'(grant_valid), 32'd0);
    chk("reset_burst_err", 32'(burst_err), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    tick();

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].v, tbl[k].l, tbl[k].rdy, tbl[k].cred);
      #2;
      chk($sformatf("rr[%0d].out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
      chk($sformatf("rr[%0d].req_ready", k), 32'(req_ready), 32'(tbl[k].e_rr));
      chk($sformatf("rr[%0d].grant_valid", k), 32'(grant_valid), 32'(tbl[k].e_gv));
      chk($sformatf("rr[%0d].grant_id", k), 32'(grant_id), 32'(tbl[k].e_gid));
      if (tbl[k].e_ov) chk($sformatf("rr[%0d].out_data", k), out_data, tbl[k].e_data);
      tick();
    end

    // Credit stall mid-packet on requester 2.
    set_data(2, 32'hB000_0001);
    drive(4'b0100, 4'b0000, 1'b1, 4'd8);
    #2;
    chk("stall.idle_out_valid", 32'(out_valid), 32'd0);
    tick();
    #2;
    chk("stall.b1_grant_id", 32'(grant_id), 32'd2);
    chk("stall.b1_out_valid", 32'(out_valid), 32'd1);
    chk("stall.b1_data", out_data, 32'hB000_0001);
    chk("stall.b1_req_ready", 32'(req_ready), 32'b0100);
    tick();
    set_data(2, 32'hB000_0002);
    credit_count = 4'd0;
    for (int c = 0; c < 4; c++) begin
      #2;
      chk($sformatf("stall[%0d].out_valid", c), 32'(out_valid), 32'd0);
      chk($sformatf("stall[%0d].req_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("stall[%0d].grant_id", c), 32'(grant_id), 32'd2);
      chk($sformatf("stall[%0d].grant_valid", c), 32'(grant_valid), 32'd1);
      tick();
    end
    credit_count = 4'd8;
    #2;
    chk("stall.b2_out_valid", 32'(out_valid), 32'd1);
    chk("stall.b2_data", out_data, 32'hB000_0002);
    tick();
    set_data(2, 32'hB000_0003);
    req_last = 4'b0100;
    #2;
    chk("stall.b3_out_valid", 32'(out_valid), 32'd1);
    chk("stall.b3_data", out_data, 32'hB000_0003);
    tick();
    drive(4'b0000, 4'b0000, 1'b1, 4'd8);
    #2;
    chk("stall.done_grant_valid", 32'(grant_valid), 32'd0);

    // Lock on requester 1 while 0 and 3 request; next grant must be 3.
    set_data(1, 32'hC000_0001);
    drive(4'b0010, 4'b0000, 1'b1, 4'd8);
    tick();
    #2;
    chk("lock.b1_grant_id", 32'(grant_id), 32'd1);
    chk("lock.b1_req_ready", 32'(req_ready), 32'b0010);
    tick();
    set_data(1, 32'hC000_0002);
    drive(4'b1011, 4'b0000, 1'b1, 4'd8);
    #2;
    chk("lock.b2_req_ready", 32'(req_ready), 32'b0010);
    chk("lock.b2_data", out_data, 32'hC000_0002);
    tick();
    set_data(1, 32'hC000_0003);
    drive(4'b1011, 4'b0010, 1'b1, 4'd8);
    #2;
    chk("lock.b3_req_ready", 32'(req_ready), 32'b0010);
    chk("lock.b3_grant_id", 32'(grant_id), 32'd1);
    tick();
    drive(4'b1001, 4'b1001, 1'b1, 4'd8);
    #2;
    chk("lock.bubble_req_ready", 32'(req_ready), 32'd0);
    chk("lock.bubble_grant_valid", 32'(grant_valid), 32'd0);
    tick();
    #2;
    chk("lock.next_grant_id", 32'(grant_id), 32'd3);
    chk("lock.next_req_ready", 32'(req_ready), 32'b1000);
    chk("lock.next_data", out_data, 32'hA000_0003);
    tick();
    drive(4'b0000, 4'b0000, 1'b1, 4'd8);
    #2;
    chk("lock.burst_err_clear", 32'(burst_err), 32'd0);

    // 5-beat packet against MAX_BURST=4.
    drive(4'b0001, 4'b0000, 1'b1, 4'd8);
    tick();
    for (int b = 1; b <= 5; b++) begin
      set_data(0, 32'hD000_0000 + DW'(b));
      req_last = (b == 5) ? 4'b0001 : 4'b0000;
      #2;
      chk($sformatf("burst[%0d].out_valid", b), 32'(out_valid), 32'd1);
      chk($sformatf("burst[%0d].data", b), out_data, 32'hD000_0000 + 32'(b));
      chk($sformatf("burst[%0d].burst_err", b), 32'(burst_err), (b >= 5) ? 32'd1 : 32'd0);
      tick();
    end
    drive(4'b0000, 4'b0000, 1'b1, 4'd8);
    #2;
    chk("burst.done_grant_valid", 32'(grant_valid), 32'd0);
    chk("burst.err_after_last", 32'(burst_err), 32'd1);
    tick();
    tick();
    chk("burst.err_sticky", 32'(burst_err), 32'd1);

    // Reset while locked on requester 2.
    set_data(0, 32'hA000_0000);
    drive(4'b0100, 4'b0000, 1'b1, 4'd8);
    tick();
    #2;
    chk("rst.locked_grant_id", 32'(grant_id), 32'd2);
    tick();
    rst = 1'b1;
    drive(4'b0101, 4'b0000, 1'b1, 4'd8);
    tick();
    rst = 1'b0;
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.grant_valid", 32'(grant_valid), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.burst_err", 32'(burst_err), 32'd0);
    tick();
    req_last = 4'b0101;
    #2;
    chk("rst.first_grant_id", 32'(grant_id), 32'd0);
    chk("rst.first_req_ready", 32'(req_ready), 32'b0001);
    tick();
    drive(4'b0000, 4'b0000, 1'b1, 4'd8);
    tick();

`ifdef FIFO_CREDIT_ARB_STATS_EN
    // Eight 1-beat packets after reset: two per requester.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4'hF, 4'hF, 1'b1, 4'd8);
    repeat (16) tick();
    drive(4'h0, 4'h0, 1'b1, 4'd8);
    #2;
    for (int i = 0; i < int'(NR); i++)
      chk($sformatf("stats.pkt_cnt[%0d]", i), 32'(pkt_cnt[i*16 +: 16]), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
